// File: rtl/trackball_counter_if.sv
// CPU-side read port of the trackball counter: read strobe and axis select
// in one direction, registered read data and its valid flag in the other.
interface trackball_counter_if #(
  parameter int COUNT_W = 8
);
  logic               rd;
  logic               addr;
  logic [COUNT_W-1:0] dout;
  logic               dout_valid;

  modport master (output rd, addr, input dout, dout_valid);
  modport slave  (input rd, addr, output dout, dout_valid);
endinterface

// File: rtl/trackball_counter.sv
// Two-axis trackball position counter: turns h/v step transitions into wrapping
// up/down counts and serves them to the CPU through a registered one-cycle read.
module trackball_counter #(
  parameter int COUNT_W       = 8,
  parameter bit CLEAR_ON_READ = 1'b0,
  parameter bit INVERT_H      = 1'b0,
  parameter bit INVERT_V      = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flip,
  input  logic                h_dir,
  input  logic                h_clk,
  input  logic                v_dir,
  input  logic                v_clk,
  trackball_counter_if.slave  bus,
  output logic [COUNT_W-1:0]  h_count,
  output logic [COUNT_W-1:0]  v_count
);

  typedef enum logic {PRIME, RUN} state_t;

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  state_t             state;
  logic               h_clk_q;
  logic               v_clk_q;
  logic [COUNT_W-1:0] dout_q;
  logic               dout_valid_q;

  logic               h_step;
  logic               v_step;
  logic               h_down;
  logic               v_down;
  logic               h_clear;
  logic               v_clear;
  logic [COUNT_W-1:0] h_next;
  logic [COUNT_W-1:0] v_next;

  // A read-clear and a step in the same cycle combine, so the step is never lost.
  always_comb begin
    h_step  = (state == RUN) && (h_clk != h_clk_q);
    v_step  = (state == RUN) && (v_clk != v_clk_q);
    h_down  = h_dir ^ flip ^ INVERT_H;
    v_down  = v_dir ^ flip ^ INVERT_V;
    h_clear = CLEAR_ON_READ && bus.rd && !bus.addr;
    v_clear = CLEAR_ON_READ && bus.rd &&  bus.addr;

    h_next = h_clear ? '0 : h_count;
    if (h_step) h_next = h_down ? (h_next - ONE) : (h_next + ONE);

    v_next = v_clear ? '0 : v_count;
    if (v_step) v_next = v_down ? (v_next - ONE) : (v_next + ONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PRIME;
      h_clk_q      <= h_clk;
      v_clk_q      <= v_clk;
      h_count      <= '0;
      v_count      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      h_clk_q      <= h_clk;
      v_clk_q      <= v_clk;
      dout_valid_q <= bus.rd;
      if (bus.rd) dout_q <= bus.addr ? v_count : h_count;

      // PRIME only re-samples the step inputs so a level held through reset is not a step.
      case (state)
        PRIME: begin
          state   <= RUN;
          h_count <= h_next;
          v_count <= v_next;
        end
        RUN: begin
          h_count <= h_next;
          v_count <= v_next;
        end
        default: state <= PRIME;
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_trackball_counter.sv
// Bench for trackball_counter: three parameter variants share one stimulus stream
// and are compared every cycle against a step-counting reference model.
module tb_trackball_counter;

  logic clk;
  logic reset;
  logic flip;
  logic h_dir;
  logic h_clk;
  logic v_dir;
  logic v_clk;
  logic rd;
  logic addr;

  logic [7:0] h_count0, v_count0;
  logic [7:0] h_count1, v_count1;
  logic [7:0] h_count2, v_count2;

  int checks = 0;
  int errors = 0;

  // Model state per variant: 0 = defaults, 1 = INVERT_H/INVERT_V, 2 = CLEAR_ON_READ
  int  m_h[3];
  int  m_v[3];
  int  m_dout[3];
  int  m_valid;
  bit  m_prime;
  bit  m_prev_h;
  bit  m_prev_v;
  bit  cfg_inv[3] = '{1'b0, 1'b1, 1'b0};
  bit  cfg_cor[3] = '{1'b0, 1'b0, 1'b1};

  trackball_counter_if #(.COUNT_W(8)) bus0 ();
  trackball_counter_if #(.COUNT_W(8)) bus1 ();
  trackball_counter_if #(.COUNT_W(8)) bus2 ();

  assign bus0.rd = rd;
  assign bus0.addr = addr;
  assign bus1.rd = rd;
  assign bus1.addr = addr;
  assign bus2.rd = rd;
  assign bus2.addr = addr;

  trackball_counter #(.COUNT_W(8), .CLEAR_ON_READ(1'b0), .INVERT_H(1'b0), .INVERT_V(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flip(flip), .h_dir(h_dir), .h_clk(h_clk),
    .v_dir(v_dir), .v_clk(v_clk), .bus(bus0), .h_count(h_count0), .v_count(v_count0)
  );

  trackball_counter #(.COUNT_W(8), .CLEAR_ON_READ(1'b0), .INVERT_H(1'b1), .INVERT_V(1'b1)) dut1 (
    .clk(clk), .reset(reset), .flip(flip), .h_dir(h_dir), .h_clk(h_clk),
    .v_dir(v_dir), .v_clk(v_clk), .bus(bus1), .h_count(h_count1), .v_count(v_count1)
  );

  trackball_counter #(.COUNT_W(8), .CLEAR_ON_READ(1'b1), .INVERT_H(1'b0), .INVERT_V(1'b0)) dut2 (
    .clk(clk), .reset(reset), .flip(flip), .h_dir(h_dir), .h_clk(h_clk),
    .v_dir(v_dir), .v_clk(v_clk), .bus(bus2), .h_count(h_count2), .v_count(v_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference: position = signed sum of counted steps mod 256, with clear-on-read
  task automatic modelStep();
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_h[k] = 0;
        m_v[k] = 0;
        m_dout[k] = 0;
      end
      m_valid = 0;
      m_prime = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        int dh;
        int dv;
        if (rd) m_dout[k] = addr ? m_v[k] : m_h[k];
        dh = 0;
        dv = 0;
        if (!m_prime && (h_clk != m_prev_h)) dh = (h_dir ^ flip ^ cfg_inv[k]) ? -1 : 1;
        if (!m_prime && (v_clk != m_prev_v)) dv = (v_dir ^ flip ^ cfg_inv[k]) ? -1 : 1;
        if (cfg_cor[k] && rd && !addr) m_h[k] = 0;
        if (cfg_cor[k] && rd &&  addr) m_v[k] = 0;
        m_h[k] = (m_h[k] + dh + 256) % 256;
        m_v[k] = (m_v[k] + dv + 256) % 256;
      end
      m_valid = rd ? 1 : 0;
      m_prime = 1'b0;
    end
    m_prev_h = h_clk;
    m_prev_v = v_clk;
  endtask

  task automatic compareAll();
    checkOutput("h_count0", h_count0, m_h[0]);
    checkOutput("v_count0", v_count0, m_v[0]);
    checkOutput("dout0", bus0.dout, m_dout[0]);
    checkOutput("dout_valid0", bus0.dout_valid, m_valid);
    checkOutput("h_count1", h_count1, m_h[1]);
    checkOutput("v_count1", v_count1, m_v[1]);
    checkOutput("dout1", bus1.dout, m_dout[1]);
    checkOutput("dout_valid1", bus1.dout_valid, m_valid);
    checkOutput("h_count2", h_count2, m_h[2]);
    checkOutput("v_count2", v_count2, m_v[2]);
    checkOutput("dout2", bus2.dout, m_dout[2]);
    checkOutput("dout_valid2", bus2.dout_valid, m_valid);
  endtask

  task automatic applyStimulus(input bit rst, input bit flp, input bit hs, input bit hd,
                               input bit vs, input bit vd, input bit r, input bit a);
    reset = rst;
    flip  = flp;
    h_dir = hd;
    v_dir = vd;
    if (hs) h_clk = ~h_clk;
    if (vs) v_clk = ~v_clk;
    rd    = r;
    addr  = a;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic resetAndPrime();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; flip = 1'b0; h_dir = 1'b0; v_dir = 1'b0;
    h_clk = 1'b0; v_clk = 1'b0; rd = 1'b0; addr = 1'b0;
    m_prev_h = 1'b0; m_prev_v = 1'b0; m_prime = 1'b1; m_valid = 0;
    for (int k = 0; k < 3; k++) begin
      m_h[k] = 0; m_v[k] = 0; m_dout[k] = 0;
    end

    // h_clk high through reset must not count; PRIME passes without a step
    h_clk = 1'b1;
    resetAndPrime();
    checkOutput("reset_h_count", h_count0, 0);
    checkOutput("reset_dout_valid", bus0.dout_valid, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("prime_h_count", h_count0, 3);

    // Vertical wrap through zero in both directions
    resetAndPrime();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("v_start", v_count0, 8'h01);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("v_wrap_down", v_count0, 8'hFF);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("v_wrap_up", v_count0, 8'h00);

    // flip alone reverses; flip with INVERT_H cancels
    resetAndPrime();
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("flip_h", h_count0, 8'hFC);
    checkOutput("flip_inv_h", h_count1, 8'h04);

    // Read returns the pre-step value while the step still lands
    resetAndPrime();
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("h_pre_read", h_count0, 8'h10);
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 0);
    checkOutput("read_dout", bus0.dout, 8'h10);
    checkOutput("read_valid", bus0.dout_valid, 1);
    checkOutput("read_h_after", h_count0, 8'h11);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("read_valid_drop", bus0.dout_valid, 0);
    checkOutput("read_dout_hold", bus0.dout, 8'h10);

    // Clear-on-read with a simultaneous down step leaves all-ones
    resetAndPrime();
    for (int i = 0; i < 32; i++) applyStimulus(0, 0, (i < 5), 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 1);
    checkOutput("cor_dout", bus2.dout, 8'h20);
    checkOutput("cor_v", v_count2, 8'hFF);
    checkOutput("cor_h_kept", h_count2, 8'h05);
    checkOutput("nocor_v", v_count0, 8'h1F);

    // Both axes step every cycle, reset pulsed mid-run
    for (int i = 0; i < 300; i++) begin
      applyStimulus((i == 150), $urandom_range(0, 1), 1, $urandom_range(0, 1),
                    1, $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
      if (i == 150) checkOutput("mid_reset_h", h_count0, 0);
    end

    // Fully random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0) ? ~flip : flip,
                    $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
